// File: rtl/modulo_confirmacao_limiar_pkg.sv
// Shared definitions for the threshold confirmation stage.
// Holds the state encoding, the default persistence depth and the comparator legality check.
package modulo_confirmacao_limiar_pkg;

    typedef enum logic [1:0] {
        NORMAL   = 2'b00,
        SUBINDO  = 2'b01,
        ALARME   = 2'b10,
        DESCENDO = 2'b11
    } estado_t;

    localparam int N_CONFIRM_DEFAULT = 4;

    // True when exactly one of the three comparator flags is set.
    function automatic logic isOneHot3(
        input logic a,
        input logic b,
        input logic c
    );
        return (a ^ b ^ c) & ~(a & b & c);
    endfunction

endpackage

// File: rtl/modulo_contador_saturado.sv
// Saturating up-counter with increment enable and synchronous clear.
// Ports: clk, reset (sync, active-high), clear, incEn -> count (holds at all-ones).
module modulo_contador_saturado #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         incEn,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (incEn && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/modulo_confirmacao_limiar.sv
// Persistence/hysteresis filter behind the 7-bit magnitude comparator.
// Ports: clk, reset, sample_valid, AltB_in/AeqB_in/AgtB_in -> alarm_out,
//        alarm_on_pulse, error_out (sticky), estado_out, alarm_count.
module modulo_confirmacao_limiar
    import modulo_confirmacao_limiar_pkg::*;
#(
    parameter int N_CONFIRM = N_CONFIRM_DEFAULT,
    parameter int CNT_W     = 4,
    parameter int EVT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_valid,
    input  logic             AltB_in,
    input  logic             AeqB_in,
    input  logic             AgtB_in,
    output logic             alarm_out,
    output logic             alarm_on_pulse,
    output logic             error_out,
    output logic [1:0]       estado_out,
    output logic [EVT_W-1:0] alarm_count
);

    localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N_CONFIRM);

    estado_t          estado;
    estado_t          nextEstado;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] nextCnt;
    logic [CNT_W-1:0] cntInc;
    logic             legal;
    logic             illegal;
    logic             enterAlarm;
    logic             pulseReg;
    logic             errorReg;

    assign legal   = sample_valid & isOneHot3(AltB_in, AeqB_in, AgtB_in);
    assign illegal = sample_valid & ~isOneHot3(AltB_in, AeqB_in, AgtB_in);
    assign cntInc  = cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            estado   <= NORMAL;
            cnt      <= '0;
            pulseReg <= 1'b0;
            errorReg <= 1'b0;
        end else begin
            estado   <= nextEstado;
            cnt      <= nextCnt;
            pulseReg <= enterAlarm;
            errorReg <= errorReg | illegal;
        end
    end

    // Illegal or absent samples fall through with state and counter held.
    always_comb begin
        nextEstado = estado;
        nextCnt    = cnt;
        enterAlarm = 1'b0;
        if (legal) begin
            unique case (estado)
                NORMAL: begin
                    nextCnt = '0;
                    if (AgtB_in) begin
                        if (N_CONFIRM == 1) begin
                            nextEstado = ALARME;
                            enterAlarm = 1'b1;
                        end else begin
                            nextEstado = SUBINDO;
                            nextCnt    = CNT_W'(1);
                        end
                    end
                end
                SUBINDO: begin
                    unique case (1'b1)
                        AgtB_in: begin
                            if (cntInc == N_CNT) begin
                                nextEstado = ALARME;
                                nextCnt    = '0;
                                enterAlarm = 1'b1;
                            end else begin
                                nextCnt = cntInc;
                            end
                        end
                        AltB_in: begin
                            nextEstado = NORMAL;
                            nextCnt    = '0;
                        end
                        AeqB_in: ;
                    endcase
                end
                ALARME: begin
                    nextCnt = '0;
                    if (AltB_in) begin
                        if (N_CONFIRM == 1) begin
                            nextEstado = NORMAL;
                        end else begin
                            nextEstado = DESCENDO;
                            nextCnt    = CNT_W'(1);
                        end
                    end
                end
                DESCENDO: begin
                    unique case (1'b1)
                        AltB_in: begin
                            if (cntInc == N_CNT) begin
                                nextEstado = NORMAL;
                                nextCnt    = '0;
                            end else begin
                                nextCnt = cntInc;
                            end
                        end
                        // Falling back into alarm is not a fresh entry.
                        AgtB_in: begin
                            nextEstado = ALARME;
                            nextCnt    = '0;
                        end
                        AeqB_in: ;
                    endcase
                end
            endcase
        end
    end

    // Both alarm states share bit 1, so the level is a flop bit.
    always_comb begin
        alarm_out      = estado[1];
        alarm_on_pulse = pulseReg;
        error_out      = errorReg;
        estado_out     = estado;
    end

    modulo_contador_saturado #(
        .W(EVT_W)
    ) uEventos (
        .clk   (clk),
        .reset (reset),
        .clear (1'b0),
        .incEn (enterAlarm),
        .count (alarm_count)
    );

endmodule

// File: tb/tb_modulo_confirmacao_limiar.sv
// Scoreboard bench for modulo_confirmacao_limiar with N_CONFIRM=4.
// Expected output snapshots are queued per sample and compared one cycle later.
module tb_modulo_confirmacao_limiar;

    typedef struct packed {
        logic       alarm;
        logic       pulse;
        logic       err;
        logic [1:0] est;
        logic [7:0] cnt;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       sample_valid;
    logic       AltB_in;
    logic       AeqB_in;
    logic       AgtB_in;
    logic       alarm_out;
    logic       alarm_on_pulse;
    logic       error_out;
    logic [1:0] estado_out;
    logic [7:0] alarm_count;

    obs_t expQ[$];
    obs_t obsQ[$];
    obs_t e;
    obs_t o;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    modulo_confirmacao_limiar dut (
        .clk            (clk),
        .reset          (reset),
        .sample_valid   (sample_valid),
        .AltB_in        (AltB_in),
        .AeqB_in        (AeqB_in),
        .AgtB_in        (AgtB_in),
        .alarm_out      (alarm_out),
        .alarm_on_pulse (alarm_on_pulse),
        .error_out      (error_out),
        .estado_out     (estado_out),
        .alarm_count    (alarm_count)
    );

    function automatic obs_t mk(
        input logic       a,
        input logic       p,
        input logic       er,
        input logic [1:0] s,
        input int         c
    );
        obs_t r;
        r.alarm = a;
        r.pulse = p;
        r.err   = er;
        r.est   = s;
        r.cnt   = 8'(c);
        return r;
    endfunction

    // Present one cycle of inputs and capture the outputs after the edge.
    task automatic step(
        input logic r,
        input logic v,
        input logic lt,
        input logic eq,
        input logic gt
    );
        reset        = r;
        sample_valid = v;
        AltB_in      = lt;
        AeqB_in      = eq;
        AgtB_in      = gt;
        @(posedge clk);
        #1;
        obsQ.push_back({alarm_out, alarm_on_pulse, error_out,
                        estado_out, alarm_count});
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            expQ.push_back(mk(0, 0, 0, 2'b00, 0));
            step(1, 0, 0, 0, 0);
        end
        for (int i = 0; i < 10; i++) begin
            expQ.push_back(mk(0, 0, 0, 2'b00, 0));
            step(0, 0, 0, 0, 0);
        end
        for (int i = 0; expQ.size() != 0; i++) begin
            e = expQ.pop_front();
            o = obsQ.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset[%0d]: got %b want %b", i, o, e);
            end
        end
    endtask

    task automatic test_confirm();
        expQ.push_back(mk(0, 0, 0, 2'b00, 0));
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            expQ.push_back(mk(0, 0, 0, 2'b01, 0));
            step(0, 1, 0, 0, 1);
        end
        expQ.push_back(mk(1, 1, 0, 2'b10, 1));
        step(0, 1, 0, 0, 1);
        expQ.push_back(mk(1, 0, 0, 2'b10, 1));
        step(0, 0, 0, 0, 0);
        for (int i = 0; expQ.size() != 0; i++) begin
            e = expQ.pop_front();
            o = obsQ.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL confirm[%0d]: got %b want %b", i, o, e);
            end
        end
    endtask

    task automatic test_eq_hold();
        expQ.push_back(mk(0, 0, 0, 2'b00, 0));
        step(1, 0, 0, 0, 0);
        expQ.push_back(mk(0, 0, 0, 2'b01, 0));
        step(0, 1, 0, 0, 1);
        expQ.push_back(mk(0, 0, 0, 2'b01, 0));
        step(0, 1, 0, 0, 1);
        expQ.push_back(mk(0, 0, 0, 2'b01, 0));
        step(0, 1, 0, 1, 0);
        expQ.push_back(mk(0, 0, 0, 2'b01, 0));
        step(0, 1, 0, 1, 0);
        expQ.push_back(mk(0, 0, 0, 2'b01, 0));
        step(0, 1, 0, 0, 1);
        expQ.push_back(mk(1, 1, 0, 2'b10, 1));
        step(0, 1, 0, 0, 1);
        for (int i = 0; expQ.size() != 0; i++) begin
            e = expQ.pop_front();
            o = obsQ.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL eq_hold[%0d]: got %b want %b", i, o, e);
            end
        end
    endtask

    task automatic test_cancel();
        expQ.push_back(mk(0, 0, 0, 2'b00, 0));
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            expQ.push_back(mk(0, 0, 0, 2'b01, 0));
            step(0, 1, 0, 0, 1);
        end
        expQ.push_back(mk(0, 0, 0, 2'b00, 0));
        step(0, 1, 1, 0, 0);
        expQ.push_back(mk(0, 0, 0, 2'b01, 0));
        step(0, 1, 0, 0, 1);
        for (int i = 0; expQ.size() != 0; i++) begin
            e = expQ.pop_front();
            o = obsQ.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL cancel[%0d]: got %b want %b", i, o, e);
            end
        end
    endtask

    task automatic test_hysteresis();
        expQ.push_back(mk(0, 0, 0, 2'b00, 0));
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            expQ.push_back(mk(0, 0, 0, 2'b01, 0));
            step(0, 1, 0, 0, 1);
        end
        expQ.push_back(mk(1, 1, 0, 2'b10, 1));
        step(0, 1, 0, 0, 1);
        expQ.push_back(mk(1, 0, 0, 2'b11, 1));
        step(0, 1, 1, 0, 0);
        expQ.push_back(mk(1, 0, 0, 2'b11, 1));
        step(0, 1, 1, 0, 0);
        expQ.push_back(mk(1, 0, 0, 2'b10, 1));
        step(0, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            expQ.push_back(mk(1, 0, 0, 2'b11, 1));
            step(0, 1, 1, 0, 0);
        end
        expQ.push_back(mk(0, 0, 0, 2'b00, 1));
        step(0, 1, 1, 0, 0);
        for (int i = 0; expQ.size() != 0; i++) begin
            e = expQ.pop_front();
            o = obsQ.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL hysteresis[%0d]: got %b want %b", i, o, e);
            end
        end
    endtask

    task automatic test_illegal();
        expQ.push_back(mk(0, 0, 0, 2'b00, 0));
        step(1, 0, 0, 0, 0);
        expQ.push_back(mk(0, 0, 0, 2'b01, 0));
        step(0, 1, 0, 0, 1);
        expQ.push_back(mk(0, 0, 0, 2'b01, 0));
        step(0, 1, 0, 0, 1);
        // Garbage without a valid strobe must be ignored silently.
        expQ.push_back(mk(0, 0, 0, 2'b01, 0));
        step(0, 0, 1, 0, 1);
        expQ.push_back(mk(0, 0, 1, 2'b01, 0));
        step(0, 1, 1, 0, 1);
        expQ.push_back(mk(0, 0, 1, 2'b01, 0));
        step(0, 1, 0, 0, 0);
        // Counter kept at 2, so two more gt samples confirm.
        expQ.push_back(mk(0, 0, 1, 2'b01, 0));
        step(0, 1, 0, 0, 1);
        expQ.push_back(mk(1, 1, 1, 2'b10, 1));
        step(0, 1, 0, 0, 1);
        expQ.push_back(mk(0, 0, 0, 2'b00, 0));
        step(1, 0, 0, 0, 0);
        expQ.push_back(mk(0, 0, 0, 2'b01, 0));
        step(0, 1, 0, 0, 1);
        expQ.push_back(mk(0, 0, 0, 2'b01, 0));
        step(0, 1, 0, 0, 1);
        expQ.push_back(mk(0, 0, 0, 2'b00, 0));
        step(1, 1, 0, 0, 1);
        for (int i = 0; expQ.size() != 0; i++) begin
            e = expQ.pop_front();
            o = obsQ.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL illegal[%0d]: got %b want %b", i, o, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        int c;
        expQ.push_back(mk(0, 0, 0, 2'b00, 0));
        step(1, 0, 0, 0, 0);
        for (int n = 1; n <= 300; n++) begin
            c = (n > 255) ? 255 : n;
            for (int i = 0; i < 3; i++) begin
                expQ.push_back(mk(0, 0, 0, 2'b01, c - ((n > 255) ? 0 : 1)));
                step(0, 1, 0, 0, 1);
            end
            expQ.push_back(mk(1, 1, 0, 2'b10, c));
            step(0, 1, 0, 0, 1);
            for (int i = 0; i < 3; i++) begin
                expQ.push_back(mk(1, 0, 0, 2'b11, c));
                step(0, 1, 1, 0, 0);
            end
            expQ.push_back(mk(0, 0, 0, 2'b00, c));
            step(0, 1, 1, 0, 0);
        end
        for (int i = 0; expQ.size() != 0; i++) begin
            e = expQ.pop_front();
            o = obsQ.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got %b want %b", i, o, e);
            end
        end
    endtask

    initial begin
        reset        = 1'b1;
        sample_valid = 1'b0;
        AltB_in      = 1'b0;
        AeqB_in      = 1'b0;
        AgtB_in      = 1'b0;
        test_reset();
        test_confirm();
        test_eq_hold();
        test_cancel();
        test_hysteresis();
        test_illegal();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
